// File: rtl/job_descriptor_fetcher.sv
`default_nettype none
// ============================================================================
// job_descriptor_fetcher
//   Fetches single or chained job descriptors over AXI4 read and dispatches
//   each one to the kernel array with a one-cycle job_start pulse.
// Revision: 1.0
// ============================================================================
module job_descriptor_fetcher #(
  parameter int DESC_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int HOLDOFF    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  manager_start,
  input  logic                  run_mode,
  input  logic [63:0]           init_addr,
  input  logic                  new_job,
  input  logic                  job_done,
  output logic                  job_start,
  output logic [DESC_WIDTH-1:0] job_desc,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DESC_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  mgr_busy,
  output logic                  mgr_error,
  output logic [31:0]           jobs_dispatched
);

  localparam int ALIGN = $clog2(DESC_WIDTH / 8);
  localparam int HW    = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_AR  = 3'd1,
    S_FETCH_R   = 3'd2,
    S_WAIT_SLOT = 3'd3,
    S_NEXT      = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic                    start_q, start_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [DESC_WIDTH-1:0]   desc_q, desc_d;
  logic [31:0]             jobs_q, jobs_d;
  logic [HW-1:0]           holdoff_q, holdoff_d;
  logic                    job_start_q, job_start_d;

  logic                    start_edge;
  logic [ADDR_WIDTH-1:0]   init_aligned;
  logic [ADDR_WIDTH-1:0]   next_aligned;

  assign start_edge   = manager_start & ~start_q;
  assign init_aligned = {init_addr[ADDR_WIDTH-1:ALIGN], {ALIGN{1'b0}}};
  assign next_aligned = {desc_q[64+ADDR_WIDTH-1:64+ALIGN], {ALIGN{1'b0}}};

  always_comb begin
    state_d     = state_q;
    start_d     = manager_start;
    cur_addr_d  = cur_addr_q;
    desc_d      = desc_q;
    jobs_d      = jobs_q;
    holdoff_d   = (holdoff_q != '0) ? holdoff_q - HW'(1) : holdoff_q;
    job_start_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_edge) begin
          cur_addr_d = init_aligned;
          jobs_d     = 32'd0;
          state_d    = S_FETCH_AR;
        end
      end
      S_FETCH_AR: begin
        if (m_axi_arready) state_d = S_FETCH_R;
      end
      S_FETCH_R: begin
        if (m_axi_rvalid) begin
          if (m_axi_rresp != 2'b00) begin
            state_d = S_ERROR;
          end else if (!m_axi_rdata[0]) begin
            state_d = S_DONE;
          end else begin
            desc_d  = m_axi_rdata;
            state_d = S_WAIT_SLOT;
          end
        end
      end
      S_WAIT_SLOT: begin
        // new_job is only trusted once the slave has had time to update busy
        if (new_job && holdoff_q == '0) begin
          job_start_d = 1'b1;
          jobs_d      = jobs_q + 32'd1;
          holdoff_d   = HW'(HOLDOFF);
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (!run_mode || desc_q[1] || next_aligned == '0) begin
          state_d = S_DONE;
        end else begin
          cur_addr_d = next_aligned;
          state_d    = S_FETCH_AR;
        end
      end
      S_ERROR: begin
        if (!manager_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b1;
      cur_addr_q  <= '0;
      desc_q      <= '0;
      jobs_q      <= 32'd0;
      holdoff_q   <= '0;
      job_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      cur_addr_q  <= cur_addr_d;
      desc_q      <= desc_d;
      jobs_q      <= jobs_d;
      holdoff_q   <= holdoff_d;
      job_start_q <= job_start_d;
    end
  end

  assign job_start       = job_start_q;
  assign job_desc        = desc_q;
  assign jobs_dispatched = jobs_q;
  assign m_axi_araddr    = cur_addr_q;
  assign m_axi_arlen     = 8'd0;
  assign m_axi_arsize    = 3'(ALIGN);
  assign m_axi_arburst   = 2'b01;
  assign m_axi_arvalid   = (state_q == S_FETCH_AR);
  assign m_axi_rready    = (state_q == S_FETCH_R);
  assign mgr_busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign mgr_error       = (state_q == S_ERROR);

  logic unused_ok;
  assign unused_ok = ^{job_done, m_axi_rlast, init_addr[ALIGN-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_job_descriptor_fetcher.sv
`default_nettype none
// Scoreboard bench for job_descriptor_fetcher: AXI read slave model plus
// monitors comparing read addresses and dispatched descriptors against queues.
module tb_job_descriptor_fetcher;
  localparam int DW = 512;
  localparam int AW = 64;
  localparam int HOLDOFF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          manager_start, run_mode, new_job, job_done;
  logic [63:0]   init_addr;
  logic          job_start;
  logic [DW-1:0] job_desc;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic          mgr_busy, mgr_error;
  logic [31:0]   jobs_dispatched;

  job_descriptor_fetcher #(.DESC_WIDTH(DW), .ADDR_WIDTH(AW), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst), .manager_start(manager_start), .run_mode(run_mode),
    .init_addr(init_addr), .new_job(new_job), .job_done(job_done),
    .job_start(job_start), .job_desc(job_desc),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .mgr_busy(mgr_busy), .mgr_error(mgr_error), .jobs_dispatched(jobs_dispatched)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [AW-1:0] ar_q[$];
  logic [DW-1:0] exp_desc_q[$];
  logic [31:0]   exp_cnt_q[$];
  logic [DW-1:0] mem [logic [63:0]];
  logic [1:0]    rresp_at [logic [63:0]];

  int js_count = 0;
  int last_js = 0;
  int prev_js = 0;
  int prev_run = -1;
  int run_id = 0;
  int start_cyc = 0;
  int rdelay = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic v, input logic l,
                                       input logic [63:0] nx, input logic [31:0] tag);
    logic [DW-1:0] d;
    d = '0;
    d[0] = v;
    d[1] = l;
    d[127:64] = nx;
    d[63:32] = tag;
    d[300:269] = tag ^ 32'h5a5a_5a5a;
    d[511:480] = ~tag;
    return d;
  endfunction

  // Monitor: read-address and dispatch scoreboard
  always @(negedge clk) begin
    if (!rst && m_axi_arvalid && m_axi_arready) begin
      if (ar_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL araddr: unexpected read at %h, none expected", m_axi_araddr);
      end else begin
        chk("araddr", 64'(m_axi_araddr), 64'(ar_q.pop_front()));
      end
      chk("ar_len_size_burst", 64'({m_axi_arlen, m_axi_arsize, m_axi_arburst}),
          64'({8'd0, 3'd6, 2'b01}));
    end
    if (!rst && job_start) begin
      js_count++;
      if (exp_desc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL job_start: unexpected dispatch, desc %h", job_desc);
      end else begin
        chkd("job_desc", job_desc, exp_desc_q.pop_front());
        chk("jobs_dispatched", 64'(jobs_dispatched), 64'(exp_cnt_q.pop_front()));
      end
      if (prev_run == run_id)
        chk("holdoff_spacing_ok", 64'((cyc - prev_js) >= HOLDOFF + 1), 64'd1);
      prev_js  = cyc;
      prev_run = run_id;
      last_js  = cyc;
    end
  end

  // AXI read slave: fixed arready, rvalid after rdelay cycles
  initial begin
    logic hs_ar, hs_r, pending;
    logic [63:0] a, paddr;
    int cnt;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b1;
    pending = 1'b0;
    paddr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      a     = m_axi_araddr;
      @(posedge clk);
      #2;
      if (rst) begin
        m_axi_rvalid = 1'b0;
        pending = 1'b0;
      end else begin
        if (hs_r) m_axi_rvalid = 1'b0;
        if (hs_ar) begin
          pending = 1'b1;
          paddr = a;
          cnt = rdelay;
        end
        if (pending && !m_axi_rvalid) begin
          if (cnt == 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = mem.exists(paddr) ? mem[paddr] : '0;
            m_axi_rresp  = rresp_at.exists(paddr) ? rresp_at[paddr] : 2'b00;
            pending = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic mode, input logic [63:0] addr);
    run_mode = mode;
    init_addr = addr;
    manager_start = 1'b1;
    job_done = 1'b0;
    run_id++;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n;
    n = 0;
    tick(1);
    while (mgr_busy && n < maxc) begin
      tick(1);
      n++;
    end
    if (mgr_busy) begin
      checks++; errors++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, maxc);
    end
    job_done = 1'b1;
  endtask

  task automatic stop_run();
    manager_start = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [DW-1:0] d1, d2a, d2b, d2c, d3, d4a, d6a;
    int js0, t, n;

    rst = 1'b1; manager_start = 1'b1; run_mode = 1'b0; init_addr = '0;
    new_job = 1'b1; job_done = 1'b1;
    tick(3);
    chk("rst job_start", 64'(job_start), 64'd0);
    chk("rst arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("rst rready", 64'(m_axi_rready), 64'd0);
    chk("rst busy", 64'(mgr_busy), 64'd0);
    chk("rst error", 64'(mgr_error), 64'd0);
    chkd("rst job_desc", job_desc, '0);
    chk("rst araddr", 64'(m_axi_araddr), 64'd0);
    chk("rst jobs", 64'(jobs_dispatched), 64'd0);
    rst = 1'b0;
    tick(5);
    chk("level over reset no start", 64'(mgr_busy), 64'd0);
    manager_start = 1'b0;
    tick(1);

    // 1: single descriptor, misaligned init address, minimum latency
    d1 = mk(1'b1, 1'b0, 64'h5000, 32'hA1);
    mem[64'h1000_0040] = d1;
    ar_q.push_back(64'h1000_0040);
    exp_desc_q.push_back(d1); exp_cnt_q.push_back(32'd1);
    start_run(1'b0, 64'h1000_0047);
    wait_idle("t1 done", 50);
    chk("t1 latency", 64'(last_js - start_cyc), 64'd4);
    chk("t1 jobs", 64'(jobs_dispatched), 64'd1);
    chkd("t1 desc stable", job_desc, d1);
    chk("t1 error", 64'(mgr_error), 64'd0);
    stop_run();

    // 2: three-descriptor chain, misaligned next pointer, last with nonzero next
    d2a = mk(1'b1, 1'b0, 64'h2000, 32'hB1);
    d2b = mk(1'b1, 1'b0, 64'h3007, 32'hB2);
    d2c = mk(1'b1, 1'b1, 64'h4000, 32'hB3);
    mem[64'h1000] = d2a; mem[64'h2000] = d2b; mem[64'h3000] = d2c;
    ar_q.push_back(64'h1000); ar_q.push_back(64'h2000); ar_q.push_back(64'h3000);
    exp_desc_q.push_back(d2a); exp_cnt_q.push_back(32'd1);
    exp_desc_q.push_back(d2b); exp_cnt_q.push_back(32'd2);
    exp_desc_q.push_back(d2c); exp_cnt_q.push_back(32'd3);
    js0 = js_count;
    start_run(1'b1, 64'h1000);
    wait_idle("t2 done", 100);
    chk("t2 jobs", 64'(jobs_dispatched), 64'd3);
    chk("t2 pulses", 64'(js_count - js0), 64'd3);
    stop_run();

    // 3: no free kernel for 20 cycles
    d3 = mk(1'b1, 1'b0, 64'h0, 32'hC1);
    mem[64'h4000] = d3;
    ar_q.push_back(64'h4000);
    exp_desc_q.push_back(d3); exp_cnt_q.push_back(32'd1);
    new_job = 1'b0;
    js0 = js_count;
    start_run(1'b0, 64'h4000);
    tick(20);
    chk("t3 held off", 64'(js_count - js0), 64'd0);
    chk("t3 busy", 64'(mgr_busy), 64'd1);
    chkd("t3 desc latched", job_desc, d3);
    new_job = 1'b1;
    t = cyc;
    wait_idle("t3 done", 50);
    chk("t3 fire delay", 64'(last_js - t), 64'd1);
    chk("t3 jobs", 64'(jobs_dispatched), 64'd1);
    stop_run();

    // 4: error response on second descriptor
    d4a = mk(1'b1, 1'b0, 64'h7000, 32'hD1);
    mem[64'h6000] = d4a;
    mem[64'h7000] = mk(1'b1, 1'b1, 64'h0, 32'hD2);
    rresp_at[64'h7000] = 2'b10;
    ar_q.push_back(64'h6000); ar_q.push_back(64'h7000);
    exp_desc_q.push_back(d4a); exp_cnt_q.push_back(32'd1);
    start_run(1'b1, 64'h6000);
    wait_idle("t4 stop", 100);
    chk("t4 error", 64'(mgr_error), 64'd1);
    tick(5);
    chk("t4 error sticky", 64'(mgr_error), 64'd1);
    chk("t4 no arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("t4 jobs", 64'(jobs_dispatched), 64'd1);
    stop_run();
    chk("t4 error cleared", 64'(mgr_error), 64'd0);
    chk("t4 idle", 64'(mgr_busy), 64'd0);

    // 5: invalid first descriptor, then restart from init_addr
    mem[64'h8000] = mk(1'b0, 1'b1, 64'h0, 32'hE1);
    ar_q.push_back(64'h8000);
    js0 = js_count;
    start_run(1'b0, 64'h8000);
    wait_idle("t5 done", 50);
    chk("t5 jobs", 64'(jobs_dispatched), 64'd0);
    chk("t5 no dispatch", 64'(js_count - js0), 64'd0);
    stop_run();
    ar_q.push_back(64'h8000);
    start_run(1'b0, 64'h8000);
    wait_idle("t5 restart", 50);
    chk("t5 refetched", 64'(ar_q.size()), 64'd0);
    stop_run();

    // 6: reset during FETCH_R of second descriptor
    d6a = mk(1'b1, 1'b0, 64'hA000, 32'hF1);
    mem[64'h9000] = d6a;
    mem[64'hA000] = mk(1'b1, 1'b1, 64'h0, 32'hF2);
    ar_q.push_back(64'h9000); ar_q.push_back(64'hA000);
    exp_desc_q.push_back(d6a); exp_cnt_q.push_back(32'd1);
    rdelay = 6;
    start_run(1'b1, 64'h9000);
    n = 0;
    tick(1);
    while (!(jobs_dispatched == 32'd1 && m_axi_rready) && n < 80) begin
      tick(1);
      n++;
    end
    chk("t6 reached second fetch", 64'(jobs_dispatched == 32'd1 && m_axi_rready), 64'd1);
    rst = 1'b1;
    tick(1);
    chk("t6 arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("t6 rready", 64'(m_axi_rready), 64'd0);
    chk("t6 job_start", 64'(job_start), 64'd0);
    chk("t6 jobs", 64'(jobs_dispatched), 64'd0);
    chk("t6 araddr", 64'(m_axi_araddr), 64'd0);
    chkd("t6 job_desc", job_desc, '0);
    rst = 1'b0;
    tick(10);
    chk("t6 no restart", 64'(mgr_busy), 64'd0);
    chk("t6 no arvalid", 64'(m_axi_arvalid), 64'd0);
    rdelay = 0;
    manager_start = 1'b0;
    tick(2);

    chk("ar queue drained", 64'(ar_q.size()), 64'd0);
    chk("desc queue drained", 64'(exp_desc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
